// File: rtl/video_mode_sequencer_if.sv
// rtl/video_mode_sequencer_if.sv - control pulses and layer-mux selects for the video mode sequencer
interface video_mode_sequencer_if;
  logic        new_frame_in;
  logic        bg_step_in;
  logic        target_step_in;
  logic        auto_toggle_in;
  logic [1:0]  bg_out;
  logic [1:0]  target_out;
  logic [23:0] crosshair_color_out;
  logic        auto_active_out;
  logic        mode_changed_out;

  // Source of the frame/button pulses, consumer of the mux selects
  modport master (
    output new_frame_in, bg_step_in, target_step_in, auto_toggle_in,
    input  bg_out, target_out, crosshair_color_out, auto_active_out, mode_changed_out
  );

  // The sequencer itself
  modport slave (
    input  new_frame_in, bg_step_in, target_step_in, auto_toggle_in,
    output bg_out, target_out, crosshair_color_out, auto_active_out, mode_changed_out
  );
endinterface

// File: rtl/video_mode_sequencer.sv
// rtl/video_mode_sequencer.sv - frame-aligned bg/overlay select sequencer; optional blink via VIDEO_MODE_SEQ_BLINK_EN
module video_mode_sequencer #(
  parameter int          DWELL_FRAMES  = 60,
  parameter int          SKIP_RESERVED = 1,
  parameter int          BLINK_FRAMES  = 15,
  parameter logic [23:0] XH_COLOR_A    = 24'h00FF00,
  parameter logic [23:0] XH_COLOR_B    = 24'hFF0000
) (
  input logic             clk_in,
  input logic             rst_in,
  video_mode_sequencer_if.slave bus
);

  localparam int            FW         = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [FW-1:0] DWELL_LAST = FW'(DWELL_FRAMES - 1);

  typedef enum logic {ST_MANUAL, ST_AUTO} state_t;

  state_t        state_q, state_d;
  logic [1:0]    bg_q, bg_d;
  logic [1:0]    tg_q, tg_d;
  logic [1:0]    pend_bg_q, pend_bg_d;
  logic [1:0]    pend_tg_q, pend_tg_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          changed_d;
  logic          changed_q;
  logic          mode_changed_q;

  // Background select walks all four codes
  function automatic logic [1:0] bg_wrap(input logic [1:0] v);
    return v + 2'd1;
  endfunction

  // Overlay select optionally skips the reserved code 2'b11
  function automatic logic [1:0] tg_wrap(input logic [1:0] v);
    if ((SKIP_RESERVED != 0) && (v >= 2'd2)) return 2'd0;
    return v + 2'd1;
  endfunction

  // State and datapath registers; reset beats every input
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_MANUAL;
      bg_q           <= 2'd0;
      tg_q           <= 2'd0;
      pend_bg_q      <= 2'd0;
      pend_tg_q      <= 2'd0;
      frame_cnt_q    <= '0;
      changed_q      <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bg_q           <= bg_d;
      tg_q           <= tg_d;
      pend_bg_q      <= pend_bg_d;
      pend_tg_q      <= pend_tg_d;
      frame_cnt_q    <= frame_cnt_d;
      changed_q      <= changed_d;
      mode_changed_q <= changed_q;
    end
  end

  // Next-state: the frame pulse is resolved in the current state before a toggle flips it
  always_comb begin
    state_d     = state_q;
    bg_d        = bg_q;
    tg_d        = tg_q;
    pend_bg_d   = pend_bg_q;
    pend_tg_d   = pend_tg_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_MANUAL: begin
        if (bus.bg_step_in)     pend_bg_d = bg_wrap(pend_bg_q);
        if (bus.target_step_in) pend_tg_d = tg_wrap(pend_tg_q);
        // Apply the pending values including a step landing on the frame pulse
        if (bus.new_frame_in) begin
          bg_d = pend_bg_d;
          tg_d = pend_tg_d;
        end
        if (bus.auto_toggle_in) begin
          state_d     = ST_AUTO;
          frame_cnt_d = '0;
        end
      end
      ST_AUTO: begin
        if (bus.new_frame_in) begin
          if (frame_cnt_q == DWELL_LAST) begin
            frame_cnt_d = '0;
            bg_d        = bg_wrap(bg_q);
            if (bg_q == 2'd3) tg_d = tg_wrap(tg_q);
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        // Seed the pending selects with what is on screen so MANUAL resumes without a jump
        if (bus.auto_toggle_in) begin
          state_d     = ST_MANUAL;
          frame_cnt_d = '0;
          pend_bg_d   = bg_d;
          pend_tg_d   = tg_d;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  // Flag a real change only; reloading the same selection stays silent
  always_comb begin
    changed_d = (bg_d != bg_q) || (tg_d != tg_q);
  end

  assign bus.bg_out           = bg_q;
  assign bus.target_out       = tg_q;
  assign bus.auto_active_out  = (state_q == ST_AUTO);
  assign bus.mode_changed_out = mode_changed_q;

`ifdef VIDEO_MODE_SEQ_BLINK_EN
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          color_b_q;

  // Crosshair colour phase, swapped on the same frame edge as the select update
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      blink_cnt_q <= '0;
      color_b_q   <= 1'b0;
    end else if (bus.new_frame_in) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        color_b_q   <= ~color_b_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign bus.crosshair_color_out = color_b_q ? XH_COLOR_B : XH_COLOR_A;
`else
  logic unused_cfg;
  assign unused_cfg = ^{XH_COLOR_B, 32'(BLINK_FRAMES)};

  assign bus.crosshair_color_out = XH_COLOR_A;
`endif

endmodule

// File: tb/tb_video_mode_sequencer.sv
// tb/tb_video_mode_sequencer.sv - directed self-checking bench for video_mode_sequencer
`timescale 1ns/1ps
module tb_video_mode_sequencer;
  localparam int          DWELL = 3;
  localparam int          BLINK = 3;
  localparam logic [23:0] COL_A = 24'h00FF00;
  localparam logic [23:0] COL_B = 24'hFF0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mc_cnt   = 0;
  int   mc_base  = 0;
  int   nf       = 0;

  video_mode_sequencer_if vif();

  video_mode_sequencer #(
    .DWELL_FRAMES (DWELL),
    .SKIP_RESERVED(1),
    .BLINK_FRAMES (BLINK),
    .XH_COLOR_A   (COL_A),
    .XH_COLOR_B   (COL_B)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  // Count change pulses away from the active edge
  always @(negedge clk) if (vif.mode_changed_out === 1'b1) mc_cnt = mc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_color();
`ifdef VIDEO_MODE_SEQ_BLINK_EN
    return (((nf / BLINK) % 2) == 1) ? COL_B : COL_A;
`else
    return COL_A;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    vif.new_frame_in   = 1'b0;
    vif.bg_step_in     = 1'b0;
    vif.target_step_in = 1'b0;
    vif.auto_toggle_in = 1'b0;
  endtask

  task automatic pulse(input logic bs, input logic ts, input logic tog);
    vif.bg_step_in     = bs;
    vif.target_step_in = ts;
    vif.auto_toggle_in = tog;
    cyc();
    clear_in();
  endtask

  task automatic frame(input logic bs, input logic ts, input logic tog);
    vif.new_frame_in   = 1'b1;
    vif.bg_step_in     = bs;
    vif.target_step_in = ts;
    vif.auto_toggle_in = tog;
    cyc();
    clear_in();
    nf = nf + 1;
    cyc();
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    nf  = 0;
    cyc();
  endtask

  task automatic check_sel(input string tag, input logic [1:0] bg, input logic [1:0] tg);
    check_eq({tag, "_bg"}, 32'(vif.bg_out), 32'(bg));
    check_eq({tag, "_tg"}, 32'(vif.target_out), 32'(tg));
  endtask

  initial begin
    clear_in();
    do_reset();
    check_sel("reset", 2'd0, 2'd0);
    check_eq("reset_auto", 32'(vif.auto_active_out), 32'd0);
    check_eq("reset_mc", 32'(vif.mode_changed_out), 32'd0);
    check_eq("reset_color", 32'(vif.crosshair_color_out), 32'(COL_A));

    // Idle frames: nothing moves
    mc_base = mc_cnt;
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 1'b0);
      check_eq("idle_color", 32'(vif.crosshair_color_out), 32'(exp_color()));
    end
    check_sel("idle", 2'd0, 2'd0);
    check_eq("idle_mc", 32'(mc_cnt - mc_base), 32'd0);

    // Mid-frame steps are held until the frame pulse, then applied with exact latency
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    cyc();
    check_sel("held", 2'd0, 2'd0);
    mc_base = mc_cnt;
    vif.new_frame_in = 1'b1;
    cyc();
    vif.new_frame_in = 1'b0;
    nf = nf + 1;
    check_sel("applied", 2'd2, 2'd1);
    check_eq("lat_mc_lo", 32'(vif.mode_changed_out), 32'd0);
    cyc();
    check_eq("lat_mc_hi", 32'(vif.mode_changed_out), 32'd1);
    cyc();
    check_eq("lat_mc_end", 32'(vif.mode_changed_out), 32'd0);
    cyc();
    check_eq("applied_mc", 32'(mc_cnt - mc_base), 32'd1);
    check_eq("applied_color", 32'(vif.crosshair_color_out), 32'(exp_color()));

    // Background wrap with a step on the frame pulse
    pulse(1'b1, 1'b0, 1'b0);
    mc_base = mc_cnt;
    frame(1'b1, 1'b0, 1'b0);
    check_sel("bg_wrap", 2'd0, 2'd1);
    check_eq("bg_wrap_mc", 32'(mc_cnt - mc_base), 32'd1);

    // Target wrap skips the reserved code
    pulse(1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    check_sel("tg_two", 2'd0, 2'd2);
    frame(1'b0, 1'b1, 1'b0);
    check_sel("tg_wrap", 2'd0, 2'd0);

    // Four bg steps in one frame cancel out and raise no pulse
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0);
    mc_base = mc_cnt;
    frame(1'b0, 1'b0, 1'b0);
    check_sel("four_steps", 2'd0, 2'd0);
    check_eq("four_steps_mc", 32'(mc_cnt - mc_base), 32'd0);
    check_eq("four_color", 32'(vif.crosshair_color_out), 32'(exp_color()));

    // AUTO demo: one advance per DWELL frames, steps ignored
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("auto_on", 32'(vif.auto_active_out), 32'd1);
    mc_base = mc_cnt;
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b1, 1'b0);
    check_sel("auto_dwell", 2'd0, 2'd0);
    frame(1'b0, 1'b0, 1'b0);
    check_sel("auto_first", 2'd1, 2'd0);
    for (int i = 0; i < 9; i++) begin
      pulse(1'b1, 1'b1, 1'b0);
      frame(1'b1, 1'b0, 1'b0);
    end
    check_sel("auto_12", 2'd0, 2'd1);
    check_eq("auto_mc", 32'(mc_cnt - mc_base), 32'd4);
    check_eq("auto_color", 32'(vif.crosshair_color_out), 32'(exp_color()));
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("auto_off", 32'(vif.auto_active_out), 32'd0);
    mc_base = mc_cnt;
    frame(1'b0, 1'b0, 1'b0);
    check_sel("manual_hold", 2'd0, 2'd1);
    check_eq("manual_hold_mc", 32'(mc_cnt - mc_base), 32'd0);

    // Reset mid-dwell restores everything
    pulse(1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    do_reset();
    check_sel("rst_mid", 2'd0, 2'd0);
    check_eq("rst_mid_auto", 32'(vif.auto_active_out), 32'd0);
    check_eq("rst_mid_mc", 32'(vif.mode_changed_out), 32'd0);
    check_eq("rst_mid_color", 32'(vif.crosshair_color_out), 32'(COL_A));
    pulse(1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    check_sel("reentry_wait", 2'd0, 2'd0);
    frame(1'b0, 1'b0, 1'b0);
    check_sel("reentry_adv", 2'd1, 2'd0);
    check_eq("reentry_color", 32'(vif.crosshair_color_out), 32'(exp_color()));

    // Toggle on the advancing frame: AUTO advances first, MANUAL keeps the result
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b1);
    check_sel("toggle_frame", 2'd2, 2'd0);
    check_eq("toggle_frame_auto", 32'(vif.auto_active_out), 32'd0);
    frame(1'b0, 1'b0, 1'b0);
    check_sel("toggle_hold", 2'd2, 2'd0);
    check_eq("final_color", 32'(vif.crosshair_color_out), 32'(exp_color()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
